// File: rtl/u712_pkg.sv
// Shared types and default cycle lengths for the U712 chip-bus cycle arbiter.
package u712_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DMA  = 3'd1,
    REG  = 3'd2,
    RAM  = 3'd3,
    TERM = 3'd4
  } state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_RAM_CYCLES  = 6;
  localparam int DEF_REG_CYCLES  = 4;
  localparam int DEF_CNT_W       = 4;

  // True for the two states that hold the bus on behalf of the CPU.
  function automatic logic is_cpu_state(input state_t s);
    return (s == REG) || (s == RAM);
  endfunction

endpackage

// File: rtl/u712_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level, with a one-clock
// rising-edge pulse derived from the synchronised value.
module u712_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;

endmodule

// File: rtl/u712_chip_cycle_arbiter.sv
// Chip-bus arbiter: slot-aligned hand-off between Agnus DMA and CPU
// chip RAM / chipset register cycles, with registered cycle flags.
module u712_chip_cycle_arbiter
  import u712_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int RAM_CYCLES  = DEF_RAM_CYCLES,
  parameter int REG_CYCLES  = DEF_REG_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic CLK40,
  input  logic RESETn,
  input  logic CCK,
  input  logic DBRn,
  input  logic RAM_REQ,
  input  logic REG_REQ,
  input  logic RnW,
  output logic DMA_CYCLE,
  output logic REG_CYCLE,
  output logic CPU_CYCLE,
  output logic CYCLE_RnW,
  output logic CYCLE_ACK
);

  logic             slot;
  logic             cck_level_unused;
  logic             dbrn_s;
  logic             dbrn_edge_unused;
  logic             dbr;
  state_t           state;
  state_t           nxt_state;
  logic [CNT_W-1:0] cnt;
  logic             cpu_start;

  u712_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b0)
  ) u_cck_sync (
    .clk   (CLK40),
    .rst_n (RESETn),
    .din   (CCK),
    .level (cck_level_unused),
    .rise  (slot)
  );

  u712_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b1)
  ) u_dbr_sync (
    .clk   (CLK40),
    .rst_n (RESETn),
    .din   (DBRn),
    .level (dbrn_s),
    .rise  (dbrn_edge_unused)
  );

  assign dbr = ~dbrn_s;

  // Slot decision shared by IDLE and the DMA exit path; REG outranks RAM.
  function automatic state_t pick(input logic d, input logic rg, input logic rm);
    if (d)       return DMA;
    else if (rg) return REG;
    else if (rm) return RAM;
    else         return IDLE;
  endfunction

  always_comb begin
    nxt_state = IDLE;
    case (state)
      IDLE:     nxt_state = slot ? pick(dbr, REG_REQ, RAM_REQ) : IDLE;
      DMA:      nxt_state = (slot && !dbr) ? pick(1'b0, REG_REQ, RAM_REQ) : DMA;
      REG, RAM: nxt_state = (cnt == CNT_W'(1)) ? TERM : state;
      TERM:     nxt_state = IDLE;
      default:  nxt_state = IDLE;
    endcase
  end

  assign cpu_start = is_cpu_state(nxt_state) && !is_cpu_state(state);

  // Outputs are decoded from the next state so they appear with the state.
  always_ff @(posedge CLK40) begin
    if (!RESETn) begin
      state     <= IDLE;
      cnt       <= '0;
      DMA_CYCLE <= 1'b0;
      REG_CYCLE <= 1'b0;
      CPU_CYCLE <= 1'b0;
      CYCLE_ACK <= 1'b0;
      CYCLE_RnW <= 1'b1;
    end else begin
      state <= nxt_state;
      if (cpu_start) begin
        CYCLE_RnW <= RnW;
        cnt       <= (nxt_state == REG) ? CNT_W'(REG_CYCLES) : CNT_W'(RAM_CYCLES);
      end else if (is_cpu_state(state)) begin
        cnt <= cnt - CNT_W'(1);
      end
      DMA_CYCLE <= (nxt_state == DMA);
      REG_CYCLE <= (nxt_state == REG);
      CPU_CYCLE <= (nxt_state == RAM);
      CYCLE_ACK <= (nxt_state == TERM);
    end
  end

endmodule

// File: tb/tb_u712_chip_cycle_arbiter.sv
// Directed bench for the U712 chip-bus cycle arbiter.
module tb_u712_chip_cycle_arbiter;

  logic CLK40 = 1'b0;
  logic RESETn = 1'b0;
  logic CCK = 1'b0;
  logic DBRn = 1'b1;
  logic RAM_REQ = 1'b0;
  logic REG_REQ = 1'b0;
  logic RnW = 1'b1;
  logic DMA_CYCLE, REG_CYCLE, CPU_CYCLE, CYCLE_RnW, CYCLE_ACK;

  int n_vec = 0;
  int n_miss = 0;

  u712_chip_cycle_arbiter dut (
    .CLK40     (CLK40),
    .RESETn    (RESETn),
    .CCK       (CCK),
    .DBRn      (DBRn),
    .RAM_REQ   (RAM_REQ),
    .REG_REQ   (REG_REQ),
    .RnW       (RnW),
    .DMA_CYCLE (DMA_CYCLE),
    .REG_CYCLE (REG_CYCLE),
    .CPU_CYCLE (CPU_CYCLE),
    .CYCLE_RnW (CYCLE_RnW),
    .CYCLE_ACK (CYCLE_ACK)
  );

  always #5 CLK40 = ~CLK40;

  task automatic step();
    @(posedge CLK40);
    #1;
  endtask

  // CCK rise; the decision taken on that slot is visible three edges later.
  task automatic cck_slot();
    CCK = 1'b1;
    step(); step(); step();
    CCK = 1'b0;
  endtask

  task automatic do_reset();
    RESETn = 1'b0; CCK = 1'b0; DBRn = 1'b1;
    RAM_REQ = 1'b0; REG_REQ = 1'b0; RnW = 1'b1;
    step(); step(); step();
    RESETn = 1'b1;
    step(); step(); step();
  endtask

  // flags = {DMA, REG, CPU, ACK, RnW}
  task automatic chk(input string name, input logic [4:0] exp);
    logic [4:0] act;
    act = {DMA_CYCLE, REG_CYCLE, CPU_CYCLE, CYCLE_ACK, CYCLE_RnW};
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got {dma,reg,cpu,ack,rnw}=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic test_reset();
    RESETn = 1'b0; DBRn = 1'b0; RAM_REQ = 1'b1; CCK = 1'b0; RnW = 1'b0;
    step(); step(); step();
    chk("reset_hold", 5'b00001);
    RESETn = 1'b1;
    step(); step(); step(); step();
    chk("reset_no_slot_yet", 5'b00001);
    cck_slot();
    chk("reset_first_slot_dma", 5'b10001);
    RAM_REQ = 1'b0; DBRn = 1'b1;
  endtask

  task automatic test_ram_read();
    do_reset();
    RAM_REQ = 1'b1; RnW = 1'b1;
    cck_slot();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("ram_rd_cyc%0d", i), 5'b00101);
      step();
    end
    chk("ram_rd_ack", 5'b00011);
    RAM_REQ = 1'b0;
    step();
    chk("ram_rd_idle", 5'b00001);
  endtask

  task automatic test_reg_priority();
    do_reset();
    REG_REQ = 1'b1; RAM_REQ = 1'b1; RnW = 1'b0;
    cck_slot();
    RnW = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reg_wr_cyc%0d", i), 5'b01000);
      step();
    end
    chk("reg_wr_ack", 5'b00010);
    REG_REQ = 1'b0; RAM_REQ = 1'b0;
    step();
    chk("reg_wr_idle_rnw_held", 5'b00000);
    step(); step(); step();
    chk("reg_wr_single_ack", 5'b00000);
  endtask

  task automatic test_dma_priority();
    do_reset();
    DBRn = 1'b0; RAM_REQ = 1'b1; RnW = 1'b1;
    step(); step(); step();
    cck_slot();
    chk("dma_wins_slot", 5'b10001);
    step(); step();
    cck_slot();
    chk("dma_held_dbr_low", 5'b10001);
    DBRn = 1'b1;
    step(); step(); step();
    chk("dma_held_no_slot", 5'b10001);
    cck_slot();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("dma_to_cpu_cyc%0d", i), 5'b00101);
      step();
    end
    chk("dma_to_cpu_ack", 5'b00011);
    RAM_REQ = 1'b0;
    step();
  endtask

  task automatic test_no_preempt();
    do_reset();
    RAM_REQ = 1'b1; RnW = 1'b1;
    cck_slot();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("nopre_cyc%0d", i), 5'b00101);
      if (i == 1) DBRn = 1'b0;
      if (i == 2) CCK = 1'b1;
      if (i == 4) CCK = 1'b0;
      step();
    end
    chk("nopre_ack", 5'b00011);
    RAM_REQ = 1'b0;
    step();
    chk("nopre_idle_wait", 5'b00001);
    step(); step();
    chk("nopre_still_idle", 5'b00001);
    cck_slot();
    chk("nopre_dma_after_slot", 5'b10001);
    DBRn = 1'b1;
  endtask

  task automatic test_mid_reset();
    int acks;
    do_reset();
    REG_REQ = 1'b1; RnW = 1'b0;
    cck_slot();
    chk("midrst_reg_start", 5'b01000);
    step();
    RESETn = 1'b0;
    step();
    chk("midrst_aborted", 5'b00001);
    RESETn = 1'b1; REG_REQ = 1'b0;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (CYCLE_ACK === 1'b1) acks++;
    end
    n_vec++;
    if (acks !== 0) begin
      n_miss++;
      $display("FAIL midrst_no_ack: got %0d ack pulses expected 0", acks);
    end
  endtask

  task automatic test_random_exclusion();
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 10000; i++) begin
      CCK = 1'($urandom_range(0, 1));
      DBRn = 1'($urandom_range(0, 1));
      RAM_REQ = 1'($urandom_range(0, 1));
      REG_REQ = 1'($urandom_range(0, 1));
      RnW = 1'($urandom_range(0, 1));
      step();
      n_vec++;
      if (!$onehot0({DMA_CYCLE, REG_CYCLE, CPU_CYCLE, CYCLE_ACK})) begin
        n_miss++;
        bad++;
        if (bad <= 5)
          $display("FAIL rand_exclusive: got {dma,reg,cpu,ack}=%b expected one-hot or zero at %0t",
                   {DMA_CYCLE, REG_CYCLE, CPU_CYCLE, CYCLE_ACK}, $time);
      end
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_ram_read();
    test_reg_priority();
    test_dma_priority();
    test_no_preempt();
    test_mid_reset();
    test_random_exclusion();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/u712_chip_cycle_arbiter.md
Name: u712_chip_cycle_arbiter

Overview:
- Sequences shared chipset data bus and buffers between Agnus DMA and CPU accesses to chip RAM and chipset registers.
- Produces registered DMA_CYCLE, REG_CYCLE and CPU_CYCLE flags that drive the buffer enable/direction logic.
- Aligns every cycle start to a colour-clock slot boundary.
- Returns a one-clock CYCLE_ACK to the CPU bus controller when the chip access completes.

Parameters:
- SYNC_STAGES, 2, flops in CCK and DBRn synchronisers (min 2).
- RAM_CYCLES, 6, CLK40 periods a CPU chip RAM cycle occupies (1..15).
- REG_CYCLES, 4, CLK40 periods a CPU chipset register cycle occupies (1..15).
- CNT_W, 4, width of cycle-length counter.

Ports:
- CLK40  input  1  system clock; all logic on rising edge.
- RESETn  input  1  synchronous active-low reset.
- CCK  input  1  Agnus colour clock, asynchronous; rising edge marks slot boundary.
- DBRn  input  1  Agnus DMA bus request, active low, asynchronous.
- RAM_REQ  input  1  CPU requests chip RAM cycle; held until CYCLE_ACK.
- REG_REQ  input  1  CPU requests chipset register cycle; held until CYCLE_ACK.
- RnW  input  1  CPU direction, valid with request.
- DMA_CYCLE  output  1  Agnus owns chip bus.
- REG_CYCLE  output  1  CPU register cycle in progress.
- CPU_CYCLE  output  1  CPU chip RAM cycle in progress.
- CYCLE_RnW  output  1  RnW latched at CPU cycle start.
- CYCLE_ACK  output  1  one-clock CPU cycle completion pulse.

Behaviour:
- Reset (RESETn low at clock edge): state IDLE, counter 0, synchronisers cleared to CCK=0 and DBRn=1. All outputs 0 except CYCLE_RnW=1.
- Reset mid-cycle aborts immediately; no CYCLE_ACK is issued.
- SLOT is internal. It is high for exactly one clock when synchronised CCK is 1 and its previous value was 0.
- DBR is the synchronised, inverted DBRn.
- All outputs are registered Moore decodes of state. Output changes are visible on the clock after the deciding edge.
- IDLE: act only on SLOT.
  - DBR=1 goes to DMA.
  - Else REG_REQ=1 goes to REG. REG beats RAM if both are asserted.
  - Else RAM_REQ=1 goes to RAM.
  - Else remain in IDLE.
  - Entering REG or RAM latches RnW into CYCLE_RnW and loads counter with REG_CYCLES or RAM_CYCLES.
- DMA: DMA_CYCLE=1. Exit only on a SLOT with DBR=0. On that edge, apply the IDLE decision directly, so a CPU cycle may start with no idle slot. Otherwise go to IDLE.
- REG: REG_CYCLE=1. RAM: CPU_CYCLE=1.
  - Counter decrements every clock.
  - When counter=1, go to TERM.
  - Total assertion equals the parameter value in clocks.
- TERM: CYCLE_ACK=1 for one clock; all cycle flags 0. Next state IDLE.
- DMA pre-emption: none. A DBR arriving during REG, RAM or TERM waits for the next SLOT after return to IDLE.
- CPU_CYCLE, REG_CYCLE and DMA_CYCLE are mutually exclusive (one-hot or all 0) at all times.
- Request dropped mid-cycle: the cycle still runs to completion and CYCLE_ACK still pulses.
- Request still high in the clock after CYCLE_ACK is treated as a new request at the next SLOT.
- CYCLE_RnW holds its value until the next CPU cycle start.
- CCK edges arriving during REG, RAM or TERM are ignored; no queuing.
- Illegal state encoding recovers to IDLE.

Decomposition:
- Shared package u712_pkg: state enum (IDLE, DMA, REG, RAM, TERM) and default cycle-length constants.
- Sub-module u712_sync_edge: SYNC_STAGES-deep synchroniser with rising-edge pulse output. Instantiated for CCK; DBRn uses the level output only.
- Arbiter FSM and counter stay in the top module.

Test Plan:
- Reset: hold RESETn=0 for 3 clocks with DBRn=0 and RAM_REQ=1 -> all flags 0, CYCLE_RnW=1. DMA_CYCLE rises only after the first SLOT following reset release.
- CPU RAM read: RAM_REQ=1, RnW=1, DBRn=1 -> CPU_CYCLE high exactly 6 clocks starting the clock after SLOT, then CYCLE_ACK for 1 clock, CYCLE_RnW=1.
- Register write vs. simultaneous RAM request: REG_REQ=1, RAM_REQ=1, RnW=0 -> REG_CYCLE high 4 clocks, CPU_CYCLE stays 0, CYCLE_RnW=0, one ACK.
- DMA priority: DBRn=0 and RAM_REQ=1 at the same SLOT -> DMA_CYCLE until the first SLOT with DBRn high, then CPU_CYCLE the next clock with no idle slot.
- No pre-emption: DBRn falls 2 clocks into RAM cycle -> CPU_CYCLE completes 6 clocks and ACK pulses. DMA_CYCLE asserts only after the next SLOT.
- Mutual exclusion and mid-cycle reset: randomised DBRn/CCK/requests for 10k clocks -> flags never overlap. RESETn=0 during REG -> REG_CYCLE 0 next clock, no ACK.
